run_controller: RTL and testbench
=================================

# run_controller

Execution controller between the hardware debug monitor and the CDECv CPU core. It turns monitor commands into a CPU clock-enable and CPU reset, so the core can run free, single-step one instruction at a time, stop on an instruction boundary, or be reset. It tracks `dbg_F0` and `dbg_halt` from the control unit and optionally stops on a PC breakpoint. It also counts executed CPU cycles.

## Interface
Parameters:
- `RST_CYCLES`, 4: number of cycles `cpu_reset` is held on a RESET command (≥1).
- `CNT_W`, 16: width of the executed-cycle counter.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset of this block.
- `cmd_valid`  in  1  the monitor presents a command.
- `cmd`  in  2  command code: 00 STOP, 01 RUN, 10 STEP, 11 RESET.
- `cmd_ready`  out  1  the block can accept a command this cycle.
- `dbg_F0`  in  1  the CPU control unit is in fetch state F0.
- `dbg_halt`  in  1  the CPU control unit is in HLT.
- `pc`  in  8  current CPU program counter.
- `bp_addr`  in  8  breakpoint address.
- `bp_en`  in  1  breakpoint armed.
- `cpu_ce`  out  1  CPU clock-enable, qualifies `we` of the CPU state registers.
- `cpu_reset`  out  1  CPU reset request, ORed with system reset at the top level.
- `status`  out  3  state code (see Operation).
- `bp_hit`  out  1  sticky flag: the last stop was caused by the breakpoint.
- `cycle_count`  out  CNT_W  number of cycles with `cpu_ce`=1.

## Operation
- A command is accepted when `cmd_valid && cmd_ready` at a rising edge. Unaccepted commands are not stored.
- States and `status` codes:
  - STOPPED=0
  - RUN=1
  - DRAIN=2
  - STEP=3
  - HALTED=4
  - CPURST=5
- `cpu_ce`=1 only in RUN, DRAIN and STEP. `cpu_reset`=1 only in CPURST. Both are Moore outputs.
- `cmd_ready`=1 in STOPPED, RUN and HALTED. It is 0 in DRAIN, STEP and CPURST.
- STOPPED:
  - RUN → RUN.
  - STEP → STEP.
  - RESET → CPURST.
  - STOP is accepted and has no effect.
- RUN, in priority order:
  - sampled `dbg_halt`=1 → HALTED.
  - accepted RESET → CPURST.
  - accepted STOP → DRAIN.
  - breakpoint match → STOPPED and `bp_hit` set.
  - RUN/STEP commands are accepted and have no effect.
- DRAIN: on sampled `dbg_F0`=1 → STOPPED; on `dbg_halt`=1 → HALTED.
- STEP: on sampled `dbg_F0`=1 → STOPPED; on `dbg_halt`=1 → HALTED. Halt takes priority when both inputs are 1.
- HALTED: RESET → CPURST. STOP, RUN and STEP are accepted and have no effect.
- CPURST: holds for exactly RST_CYCLES cycles, then → STOPPED.
  - `cycle_count` clears to 0 on entry.
  - `bp_hit` clears on entry.
- `bp_hit` clears on any accepted command and is otherwise sticky.
- `cycle_count` increments by 1 each cycle with `cpu_ce`=1 and wraps modulo 2^CNT_W.
- Async `reset`, effective immediately:
  - state STOPPED, `cpu_ce`=0, `cpu_reset`=0.
  - `bp_hit`=0, `cycle_count`=0, `status`=0, `cmd_ready`=1.
  - Asserting `reset` mid-STEP, DRAIN or CPURST abandons the operation without completing it.

## Timing
- The CPU state register updates on the falling edge. `cpu_ce` is registered on the rising edge, so it is stable across the falling edge.
- During a cycle with `cpu_ce`=1, the CPU advances at the falling edge. The controller samples the resulting `dbg_F0`, `dbg_halt` and `pc` at the next rising edge.
- Command latency: a command accepted at edge k changes `cpu_ce`/`cpu_reset` from edge k onward, i.e. in cycle k+1.
- STEP from F0 of an n-cycle instruction: `cpu_ce` is high for exactly n cycles. It drops in the cycle after F0 is sampled again.
- A STEP issued while stopped mid-instruction (only possible after a system reset) runs to the next F0.
- Breakpoint is evaluated only in RUN and only on sampled `dbg_F0`=1. The CPU stops with F0 pending at `pc`==`bp_addr`, and that instruction is not executed.
- Because resuming RUN at the breakpoint address executes at least one cycle before the next F0 sample, the breakpoint does not re-fire immediately.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined: the breakpoint comparator is present and behaves as described above.
- Not defined:
  - `bp_addr` and `bp_en` are ignored; no comparator is synthesised.
  - RUN never stops on a breakpoint, and `bp_hit` is constant 0.
  - All other behaviour is identical.

## Test plan
- Reset: assert `reset` asynchronously mid-RUN → immediately `cpu_ce`=0, `status`=0, `cycle_count`=0, `cmd_ready`=1.
- Single step: from STOPPED at F0, 3-cycle instruction model, STEP → `cpu_ce` high exactly 3 cycles, `status` 3→0, `cycle_count`=3, `cmd_ready` low throughout.
- Drain: RUN, then STOP issued while the CPU is 1 cycle into a 4-cycle instruction → `status`=2, then `cpu_ce` stays high 3 more cycles, then `status`=0 with `dbg_F0`=1.
- Halt: RUN until `dbg_halt`=1 → `status`=4, `cpu_ce`=0. RUN then ignored; RESET → `cpu_reset` high exactly 4 cycles, `cycle_count`=0, `status`=0.
- Breakpoint (macro defined): `bp_en`=1, `bp_addr`=8'h10, RUN reaches F0 with `pc`=8'h10 → `status`=0, `bp_hit`=1. RUN again → `bp_hit`=0, no immediate re-stop. With macro undefined, the same stimulus keeps `status`=1.
- Counter wrap: force 65535 enabled cycles, then 1 more → `cycle_count`=0.

Source files
------------

// File: rtl/run_controller.sv
// rtl/run_controller.sv - CDECv run/step/stop/reset execution controller; optional breakpoint via RUN_CTRL_BREAKPOINT_EN
module run_controller #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             dbg_F0,
  input  logic             dbg_halt,
  input  logic [7:0]       pc,
  input  logic [7:0]       bp_addr,
  input  logic             bp_en,
  output logic             cpu_ce,
  output logic             cpu_reset,
  output logic [2:0]       status,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_STOPPED = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_STEP    = 3'd3,
    S_HALTED  = 3'd4,
    S_CPURST  = 3'd5
  } state_t;

  localparam logic [1:0] CMD_STOP  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  // Hold counter only needs to reach RST_CYCLES-1
  localparam int          RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RW-1:0]      r_rst_cnt;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               r_bp_hit;
  logic               w_accept;
  logic               w_bp_match;
  logic               w_bp_stop;
  logic               w_enter_rst;

  assign w_accept = cmd_valid && cmd_ready;

`ifdef RUN_CTRL_BREAKPOINT_EN
  // Breakpoint fires only on an instruction boundary, before the instruction at bp_addr executes
  assign w_bp_match = bp_en && dbg_F0 && (pc == bp_addr);
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{bp_en, bp_addr, pc};
  assign w_bp_match  = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_STOPPED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; halt beats everything, then commands, then breakpoint
  always_comb begin
    w_state_nxt = r_state;
    w_bp_stop   = 1'b0;
    case (r_state)
      S_STOPPED: begin
        if (w_accept) begin
          if (cmd == CMD_RUN) begin
            w_state_nxt = S_RUN;
          end else if (cmd == CMD_STEP) begin
            w_state_nxt = S_STEP;
          end else if (cmd == CMD_RESET) begin
            w_state_nxt = S_CPURST;
          end
        end
      end
      S_RUN: begin
        if (dbg_halt) begin
          w_state_nxt = S_HALTED;
        end else if (w_accept && (cmd == CMD_RESET)) begin
          w_state_nxt = S_CPURST;
        end else if (w_accept && (cmd == CMD_STOP)) begin
          w_state_nxt = S_DRAIN;
        end else if (w_bp_match) begin
          w_state_nxt = S_STOPPED;
          w_bp_stop   = 1'b1;
        end
      end
      S_DRAIN, S_STEP: begin
        if (dbg_halt) begin
          w_state_nxt = S_HALTED;
        end else if (dbg_F0) begin
          w_state_nxt = S_STOPPED;
        end
      end
      S_HALTED: begin
        if (w_accept && (cmd == CMD_RESET)) begin
          w_state_nxt = S_CPURST;
        end
      end
      S_CPURST: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = S_STOPPED;
        end
      end
      default: begin
        w_state_nxt = S_STOPPED;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register
  always_comb begin
    cpu_ce    = 1'b0;
    cpu_reset = 1'b0;
    cmd_ready = 1'b0;
    case (r_state)
      S_STOPPED: cmd_ready = 1'b1;
      S_RUN: begin
        cpu_ce    = 1'b1;
        cmd_ready = 1'b1;
      end
      S_DRAIN:  cpu_ce    = 1'b1;
      S_STEP:   cpu_ce    = 1'b1;
      S_HALTED: cmd_ready = 1'b1;
      S_CPURST: cpu_reset = 1'b1;
      default: begin
        cpu_ce    = 1'b0;
        cpu_reset = 1'b0;
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign status      = r_state;
  assign bp_hit      = r_bp_hit;
  assign cycle_count = r_cycle_count;

  assign w_enter_rst = (w_state_nxt == S_CPURST) && (r_state != S_CPURST);

  // CPU reset hold timer, restarted on every entry to CPURST
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rst_cnt <= '0;
    end else if (w_enter_rst) begin
      r_rst_cnt <= '0;
    end else if ((r_state == S_CPURST) && (r_rst_cnt != RST_LAST)) begin
      r_rst_cnt <= r_rst_cnt + RW'(1);
    end
  end

  // Executed-cycle counter; clear on CPU reset wins over the final enabled cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_enter_rst) begin
      r_cycle_count <= '0;
    end else if (cpu_ce) begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  // Sticky breakpoint flag; a breakpoint stop in the same cycle as an accepted no-op command still sets it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bp_hit <= 1'b0;
    end else if (w_bp_stop) begin
      r_bp_hit <= 1'b1;
    end else if (w_accept || w_enter_rst) begin
      r_bp_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - scoreboard bench for run_controller with a variable-length instruction CPU model
module tb_run_controller;

  localparam logic [1:0] C_STOP  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_RESET = 2'b11;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic        dbg_F0;
  logic        dbg_halt;
  logic [7:0]  pc;
  logic [7:0]  bp_addr;
  logic        bp_en;
  logic        cpu_ce;
  logic        cpu_reset;
  logic [2:0]  status;
  logic        bp_hit;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  // CPU model: instruction at address a takes ilen[a] enabled cycles, F0 is phase 0
  int         ilen [256];
  int         m_phase;
  logic [7:0] m_pc;
  logic       halt_en;
  logic [7:0] halt_addr;

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       ce;
    logic       rst;
    logic [2:0] st;
    logic       rdy;
  } ent_t;

  ent_t sb[$];

  run_controller #(.RST_CYCLES(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .dbg_F0(dbg_F0), .dbg_halt(dbg_halt), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_ce(cpu_ce), .cpu_reset(cpu_reset), .status(status), .bp_hit(bp_hit),
    .cycle_count(cycle_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      m_pc    <= 8'd0;
      m_phase <= 0;
    end else if (cpu_reset) begin
      m_pc    <= 8'd0;
      m_phase <= 0;
    end else if (cpu_ce) begin
      if (m_phase + 1 >= ilen[m_pc]) begin
        m_phase <= 0;
        m_pc    <= m_pc + 8'd1;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  assign dbg_F0   = (m_phase == 0);
  assign dbg_halt = halt_en && (m_pc == halt_addr) && (m_phase == 1);
  assign pc       = m_pc;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic v, input logic [1:0] c, input logic ce, input logic rst,
                      input logic [2:0] st, input logic rdy, input int n);
    ent_t e;
    e.v = v; e.c = c; e.ce = ce; e.rst = rst; e.st = st; e.rdy = rdy;
    repeat (n) sb.push_back(e);
  endtask

  task automatic test_reset();
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL reset_status got %0d want 0", status); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", cpu_ce); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL reset_cpurst got %b want 0", cpu_reset); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bphit got %b want 0", bp_hit); end
    @(posedge clock); #1; reset = 1'b0;
    tick();
    // run four enabled cycles, then assert reset asynchronously mid-cycle
    cmd_valid = 1'b1; cmd = C_RUN; tick(); cmd_valid = 1'b0;
    repeat (4) tick();
    checks++; if (status !== 3'd1 || cycle_count !== 16'd4) begin
      errors++; $display("FAIL midrun_state got st=%0d cnt=%0d want st=1 cnt=4", status, cycle_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if ({cpu_ce, status, cmd_ready} !== {1'b0, 3'd0, 1'b1} || cycle_count !== 16'd0) begin
      errors++; $display("FAIL async_reset got ce=%b st=%0d rdy=%b cnt=%0d want ce=0 st=0 rdy=1 cnt=0",
                         cpu_ce, status, cmd_ready, cycle_count);
    end
    @(posedge clock); #1; reset = 1'b0;
    tick();
  endtask

  task automatic test_step();
    ent_t e;
    int   i = 0;
    push(1'b1, C_STEP, 1'b1, 1'b0, 3'd3, 1'b0, 1);
    push(1'b0, C_STOP, 1'b1, 1'b0, 3'd3, 1'b0, 2);
    push(1'b0, C_STOP, 1'b0, 1'b0, 3'd0, 1'b1, 2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmd_valid = e.v; cmd = e.c; tick(); cmd_valid = 1'b0;
      checks++;
      if ({cpu_ce, cpu_reset, status, cmd_ready} !== {e.ce, e.rst, e.st, e.rdy}) begin
        errors++; $display("FAIL step[%0d] ce/rst/st/rdy got %b/%b/%0d/%b want %b/%b/%0d/%b",
                           i, cpu_ce, cpu_reset, status, cmd_ready, e.ce, e.rst, e.st, e.rdy);
      end
      i++;
    end
    checks++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL step_count got %0d want 3", cycle_count); end
  endtask

  task automatic test_drain();
    ent_t e;
    int   i = 0;
    push(1'b1, C_RUN,   1'b1, 1'b0, 3'd1, 1'b1, 1);
    push(1'b1, C_STOP,  1'b1, 1'b0, 3'd2, 1'b0, 1);
    push(1'b1, C_RESET, 1'b1, 1'b0, 3'd2, 1'b0, 1);
    push(1'b0, C_STOP,  1'b1, 1'b0, 3'd2, 1'b0, 1);
    push(1'b0, C_STOP,  1'b0, 1'b0, 3'd0, 1'b1, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmd_valid = e.v; cmd = e.c; tick(); cmd_valid = 1'b0;
      checks++;
      if ({cpu_ce, cpu_reset, status, cmd_ready} !== {e.ce, e.rst, e.st, e.rdy}) begin
        errors++; $display("FAIL drain[%0d] ce/rst/st/rdy got %b/%b/%0d/%b want %b/%b/%0d/%b",
                           i, cpu_ce, cpu_reset, status, cmd_ready, e.ce, e.rst, e.st, e.rdy);
      end
      i++;
    end
    checks++; if (cycle_count !== 16'd7) begin errors++; $display("FAIL drain_count got %0d want 7", cycle_count); end
  endtask

  task automatic test_halt();
    ent_t e;
    int   i = 0;
    halt_addr = 8'd3;
    halt_en   = 1'b1;
    push(1'b1, C_RUN,  1'b1, 1'b0, 3'd1, 1'b1, 1);
    push(1'b0, C_STOP, 1'b1, 1'b0, 3'd1, 1'b1, 2);
    push(1'b0, C_STOP, 1'b0, 1'b0, 3'd4, 1'b1, 1);
    push(1'b1, C_RUN,  1'b0, 1'b0, 3'd4, 1'b1, 1);
    push(1'b1, C_STEP, 1'b0, 1'b0, 3'd4, 1'b1, 1);
    push(1'b1, C_STOP, 1'b0, 1'b0, 3'd4, 1'b1, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmd_valid = e.v; cmd = e.c; tick(); cmd_valid = 1'b0;
      checks++;
      if ({cpu_ce, cpu_reset, status, cmd_ready} !== {e.ce, e.rst, e.st, e.rdy}) begin
        errors++; $display("FAIL halt[%0d] ce/rst/st/rdy got %b/%b/%0d/%b want %b/%b/%0d/%b",
                           i, cpu_ce, cpu_reset, status, cmd_ready, e.ce, e.rst, e.st, e.rdy);
      end
      i++;
    end
    checks++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL halt_count got %0d want 10", cycle_count); end
    halt_en = 1'b0;
    i = 0;
    push(1'b1, C_RESET, 1'b0, 1'b1, 3'd5, 1'b0, 1);
    push(1'b0, C_STOP,  1'b0, 1'b1, 3'd5, 1'b0, 3);
    push(1'b0, C_STOP,  1'b0, 1'b0, 3'd0, 1'b1, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmd_valid = e.v; cmd = e.c; tick(); cmd_valid = 1'b0;
      checks++;
      if ({cpu_ce, cpu_reset, status, cmd_ready} !== {e.ce, e.rst, e.st, e.rdy}) begin
        errors++; $display("FAIL cpurst[%0d] ce/rst/st/rdy got %b/%b/%0d/%b want %b/%b/%0d/%b",
                           i, cpu_ce, cpu_reset, status, cmd_ready, e.ce, e.rst, e.st, e.rdy);
      end
      i++;
    end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL cpurst_count got %0d want 0", cycle_count); end
  endtask

  task automatic test_breakpoint();
    ent_t e;
    int   i = 0;
    int   total = 0;
    int   n = 0;
    for (int a = 0; a < 16; a++) total += ilen[a];
    bp_en   = 1'b1;
    bp_addr = 8'h10;
`ifdef RUN_CTRL_BREAKPOINT_EN
    push(1'b1, C_RUN,  1'b1, 1'b0, 3'd1, 1'b1, 1);
    push(1'b0, C_STOP, 1'b1, 1'b0, 3'd1, 1'b1, total - 1);
    push(1'b0, C_STOP, 1'b0, 1'b0, 3'd0, 1'b1, 1);
`else
    push(1'b1, C_RUN,  1'b1, 1'b0, 3'd1, 1'b1, 1);
    push(1'b0, C_STOP, 1'b1, 1'b0, 3'd1, 1'b1, total);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmd_valid = e.v; cmd = e.c; tick(); cmd_valid = 1'b0;
      checks++;
      if ({cpu_ce, cpu_reset, status, cmd_ready} !== {e.ce, e.rst, e.st, e.rdy}) begin
        errors++; $display("FAIL bp[%0d] ce/rst/st/rdy got %b/%b/%0d/%b want %b/%b/%0d/%b",
                           i, cpu_ce, cpu_reset, status, cmd_ready, e.ce, e.rst, e.st, e.rdy);
      end
      i++;
    end
`ifdef RUN_CTRL_BREAKPOINT_EN
    checks++; if (bp_hit !== 1'b1 || cycle_count !== 16'(total)) begin
      errors++; $display("FAIL bp_stop got hit=%b cnt=%0d want hit=1 cnt=%0d", bp_hit, cycle_count, total);
    end
    i = 0;
    push(1'b1, C_RUN,  1'b1, 1'b0, 3'd1, 1'b1, 1);
    push(1'b0, C_STOP, 1'b1, 1'b0, 3'd1, 1'b1, 3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmd_valid = e.v; cmd = e.c; tick(); cmd_valid = 1'b0;
      checks++;
      if ({cpu_ce, cpu_reset, status, cmd_ready, bp_hit} !== {e.ce, e.rst, e.st, e.rdy, 1'b0}) begin
        errors++; $display("FAIL bp_resume[%0d] ce/rst/st/rdy/hit got %b/%b/%0d/%b/%b want %b/%b/%0d/%b/0",
                           i, cpu_ce, cpu_reset, status, cmd_ready, bp_hit, e.ce, e.rst, e.st, e.rdy);
      end
      i++;
    end
`else
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_disabled_hit got %b want 0", bp_hit); end
`endif
    bp_en = 1'b0;
    cmd_valid = 1'b1; cmd = C_STOP; tick(); cmd_valid = 1'b0;
    while (status !== 3'd0 && n < 20) begin tick(); n++; end
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL bp_drain_timeout got st=%0d want 0", status); end
  endtask

  task automatic test_counter_wrap();
    int n = 0;
    cmd_valid = 1'b1; cmd = C_RESET; tick(); cmd_valid = 1'b0;
    repeat (5) tick();
    checks++; if (status !== 3'd0 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL wrap_prep got st=%0d cnt=%0d want st=0 cnt=0", status, cycle_count);
    end
    cmd_valid = 1'b1; cmd = C_RUN; tick(); cmd_valid = 1'b0;
    repeat (65535) tick();
    checks++; if (cycle_count !== 16'hFFFF || status !== 3'd1) begin
      errors++; $display("FAIL wrap_max got cnt=%0d st=%0d want cnt=65535 st=1", cycle_count, status);
    end
    tick();
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", cycle_count); end
    cmd_valid = 1'b1; cmd = C_STOP; tick(); cmd_valid = 1'b0;
    while (status !== 3'd0 && n < 20) begin tick(); n++; end
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL wrap_drain_timeout got st=%0d want 0", status); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) ilen[a] = 3;
    ilen[1]   = 4;
    ilen[2]   = 2;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = C_STOP;
    bp_en     = 1'b0;
    bp_addr   = 8'h00;
    halt_en   = 1'b0;
    halt_addr = 8'hFF;
    #12;
    test_reset();
    test_step();
    test_drain();
    test_halt();
    test_breakpoint();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
